control_sequencer: RTL and testbench

//  Owns the multicycle control FSM's state register, instruction register (IR) and status register.

---
 rtl/control_sequencer.sv | 143 ++++++++++++++
 tb/tb_control_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multicycle control sequencer: state register, instruction register, status flags and retired count.
// Latency: strobes are same-cycle Moore decodes of the registered state; registers update on the next edge.
// Backpressure: stall=1 freezes every register and forces all strobes (and instr_done) low for that cycle.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall                 hold-everything qualifier
//   next_state            next state from the external next-state logic
//   mem_rdata, alu_flags  IR and status_reg capture sources
//   state, instr,
//   status_reg, retired   registered outputs fed back to next-state logic / counters
//   ir_load .. alu_op     datapath and memory control decodes
//   instr_done            last cycle of the current instruction
module control_sequencer #(
    parameter int STATE_W = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [STATE_W-1:0] next_state,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic [3:0]         alu_flags,
    output logic [STATE_W-1:0] state,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         status_reg,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               rf_we,
    output logic               mem_we,
    output logic               flags_we,
    output logic [2:0]         alu_op,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [STATE_W-1:0] S_IDLE = STATE_W'(8'h00);

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;

    logic [STATE_W-1:0] state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [3:0]         status_q, status_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    // Raw decodes of the registered state, before stall/reset qualification.
    logic dec_ir_load, dec_pc_inc, dec_pc_load, dec_rf_we, dec_mem_we, dec_flags_we;
    logic [2:0] dec_alu_op;
    logic       active;

    always_comb begin
        dec_ir_load  = 1'b0;
        dec_pc_inc   = 1'b0;
        dec_pc_load  = 1'b0;
        dec_rf_we    = 1'b0;
        dec_mem_we   = 1'b0;
        dec_flags_we = 1'b0;
        dec_alu_op   = ALU_PASS;

        case (state_q)
            STATE_W'(8'h0F): dec_ir_load = 1'b1;
            STATE_W'(8'h01): dec_pc_inc  = 1'b1;
            STATE_W'(8'h04), STATE_W'(8'h05), STATE_W'(8'h2D),
            STATE_W'(8'h24), STATE_W'(8'h25): dec_pc_load = 1'b1;
            STATE_W'(8'h15), STATE_W'(8'h1D): dec_mem_we  = 1'b1;
            default: ;
        endcase

        // Writeback states of add/sub/xor/mul also latch flags; 0x27 is a flag-only compare.
        case (state_q)
            STATE_W'(8'h0B), STATE_W'(8'h08), STATE_W'(8'h0E),
            STATE_W'(8'h12): begin
                dec_rf_we    = 1'b1;
                dec_flags_we = 1'b1;
            end
            STATE_W'(8'h02), STATE_W'(8'h03), STATE_W'(8'h1A): dec_rf_we = 1'b1;
            STATE_W'(8'h27): dec_flags_we = 1'b1;
            default: ;
        endcase

        case (state_q)
            STATE_W'(8'h09), STATE_W'(8'h0A), STATE_W'(8'h0B): dec_alu_op = ALU_ADD;
            STATE_W'(8'h06), STATE_W'(8'h07), STATE_W'(8'h08),
            STATE_W'(8'h26), STATE_W'(8'h27): dec_alu_op = ALU_SUB;
            STATE_W'(8'h0C), STATE_W'(8'h0D), STATE_W'(8'h0E): dec_alu_op = ALU_XOR;
            STATE_W'(8'h28), STATE_W'(8'h10), STATE_W'(8'h11),
            STATE_W'(8'h12): dec_alu_op = ALU_MUL;
            default: dec_alu_op = ALU_PASS;
        endcase
    end

    // Reset is folded in so nothing pulses in the window between reset rising and the flops clearing.
    assign active = !stall && !reset;

    assign ir_load    = active && dec_ir_load;
    assign pc_inc     = active && dec_pc_inc;
    assign pc_load    = active && dec_pc_load;
    assign rf_we      = active && dec_rf_we;
    assign mem_we     = active && dec_mem_we;
    assign flags_we   = active && dec_flags_we;
    // alu_op is a mux select rather than a write strobe, so it stays valid during stall.
    assign alu_op     = reset ? ALU_PASS : dec_alu_op;
    assign instr_done = active && (state_q != S_IDLE) && (next_state == S_IDLE);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        status_d  = status_q;
        retired_d = retired_q;
        if (!stall) begin
            state_d = next_state;
            if (dec_ir_load)  instr_d  = mem_rdata;
            if (dec_flags_we) status_d = alu_flags;
            if (instr_done)   retired_d = retired_q + CNT_W'(1);  // wraps naturally
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            status_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            status_q  <= status_d;
            retired_q <= retired_d;
        end
    end

    assign state      = state_q;
    assign instr      = instr_q;
    assign status_reg = status_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: scoreboard of expected per-cycle outputs plus directed scenario checks.
// Latency: each stimulus cycle pushes one expected record, popped and compared at the following negedge.
// Backpressure: stall is driven directly by the stimulus; expected strobes are zero in stalled cycles.
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [7:0]  next_state;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_flags;

    logic [7:0]  state;
    logic [15:0] instr;
    logic [3:0]  status_reg;
    logic        ir_load, pc_inc, pc_load, rf_we, mem_we, flags_we, instr_done;
    logic [2:0]  alu_op;
    logic [15:0] retired;

    // Narrow-counter instance, sharing all inputs, so the counter wrap is reachable quickly.
    logic [7:0]  state_b;
    logic [15:0] instr_b;
    logic [3:0]  status_b;
    logic        ir_load_b, pc_inc_b, pc_load_b, rf_we_b, mem_we_b, flags_we_b, instr_done_b;
    logic [2:0]  alu_op_b;
    logic [7:0]  retired_b;

    control_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .next_state(next_state),
        .mem_rdata(mem_rdata), .alu_flags(alu_flags),
        .state(state), .instr(instr), .status_reg(status_reg),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we),
        .mem_we(mem_we), .flags_we(flags_we), .alu_op(alu_op),
        .instr_done(instr_done), .retired(retired)
    );

    control_sequencer #(.CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .next_state(next_state),
        .mem_rdata(mem_rdata), .alu_flags(alu_flags),
        .state(state_b), .instr(instr_b), .status_reg(status_b),
        .ir_load(ir_load_b), .pc_inc(pc_inc_b), .pc_load(pc_load_b), .rf_we(rf_we_b),
        .mem_we(mem_we_b), .flags_we(flags_we_b), .alu_op(alu_op_b),
        .instr_done(instr_done_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  st;
        logic [15:0] ir;
        logic [3:0]  sr;
        logic [15:0] ret;
        logic [5:0]  strb;     // {ir_load,pc_inc,pc_load,rf_we,mem_we,flags_we}
        logic [2:0]  alu;
        logic        alu_vld;
        logic        done;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the architectural registers.
    logic [7:0]  m_state;
    logic [15:0] m_instr;
    logic [3:0]  m_status;
    logic [15:0] m_ret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_strb(input logic [7:0] s);
        logic il, pi, pl, rw, mw, fw;
        il = (s == 8'h0F);
        pi = (s == 8'h01);
        pl = s inside {8'h04, 8'h05, 8'h2D, 8'h24, 8'h25};
        rw = s inside {8'h02, 8'h03, 8'h0B, 8'h08, 8'h0E, 8'h1A, 8'h12};
        mw = s inside {8'h15, 8'h1D};
        fw = s inside {8'h0B, 8'h08, 8'h0E, 8'h27, 8'h12};
        return {il, pi, pl, rw, mw, fw};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [7:0] s);
        if (s inside {[8'h09:8'h0B]})                return 3'b001;
        if (s inside {[8'h06:8'h08], [8'h26:8'h27]}) return 3'b010;
        if (s inside {[8'h0C:8'h0E]})                return 3'b011;
        if (s inside {8'h28, [8'h10:8'h12]})         return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_state  = 8'h00;
        m_instr  = 16'h0;
        m_status = 4'h0;
        m_ret    = 16'h0;
        sb_q.delete();
    endtask

    // One clock cycle: called at posedge+1; drives inputs, scoreboards, returns at next posedge+1.
    task automatic cyc(input logic [7:0] ns, input logic [15:0] rd, input logic [3:0] fl, input logic stl);
        exp_t e, g;
        logic [5:0] strb;
        next_state = ns;
        mem_rdata  = rd;
        alu_flags  = fl;
        stall      = stl;
        strb       = exp_strb(m_state);
        e.st      = m_state;
        e.ir      = m_instr;
        e.sr      = m_status;
        e.ret     = m_ret;
        e.strb    = stl ? 6'b0 : strb;
        e.alu     = exp_alu(m_state);
        e.alu_vld = !stl;
        e.done    = !stl && (m_state != 8'h00) && (ns == 8'h00);
        sb_q.push_back(e);

        @(negedge clk);
        g = sb_q.pop_front();
        chk($sformatf("state@%0h", g.st), state, g.st);
        chk($sformatf("instr@%0h", g.st), instr, g.ir);
        chk($sformatf("status@%0h", g.st), status_reg, g.sr);
        chk($sformatf("retired@%0h", g.st), retired, g.ret);
        chk($sformatf("strobes@%0h", g.st),
            {ir_load, pc_inc, pc_load, rf_we, mem_we, flags_we}, g.strb);
        chk($sformatf("done@%0h", g.st), instr_done, g.done);
        if (g.alu_vld) chk($sformatf("alu_op@%0h", g.st), alu_op, g.alu);
        chk($sformatf("narrow@%0h", g.st),
            {state_b, instr_b, status_b, ir_load_b, pc_inc_b, pc_load_b, rf_we_b,
             mem_we_b, flags_we_b, instr_done_b, retired_b},
            {g.st, g.ir, g.sr, g.strb, g.done, g.ret[7:0]});
        if (g.alu_vld) chk($sformatf("narrow_alu@%0h", g.st), alu_op_b, g.alu);

        @(posedge clk);
        if (!stl) begin
            if (strb[5]) m_instr  = rd;
            if (strb[0]) m_status = fl;
            if (m_state != 8'h00 && ns == 8'h00) m_ret = m_ret + 16'd1;
            m_state = ns;
        end
        #1;
    endtask

    logic [7:0] sweep [24] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C,
                               8'h0D, 8'h0E, 8'h10, 8'h11, 8'h12, 8'h15, 8'h1A, 8'h1D,
                               8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h2D, 8'h30, 8'hFF};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        next_state = 8'h00;
        mem_rdata  = 16'h0;
        alu_flags  = 4'h0;
        model_reset();

        // Reset state, with inputs that would otherwise do something.
        next_state = 8'h0F;
        alu_flags  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 8'h00);
        chk("rst_instr", instr, 16'h0);
        chk("rst_status", status_reg, 4'h0);
        chk("rst_retired", retired, 16'h0);
        chk("rst_strobes", {ir_load, pc_inc, pc_load, rf_we, mem_we, flags_we, instr_done}, 7'b0);
        chk("rst_alu", alu_op, 3'b000);
        reset = 1'b0;

        // Fetch: 0x00 -> 0x0F -> 0x01 -> 0x00.
        cyc(8'h0F, 16'hDEAD, 4'h0, 1'b0);
        cyc(8'h01, 16'h2123, 4'h0, 1'b0);
        chk("fetch_ir", instr, 16'h2123);
        cyc(8'h00, 16'hBEEF, 4'h0, 1'b0);
        chk("fetch_ir_hold", instr, 16'h2123);
        chk("fetch_retired", retired, 16'h0001);

        // Add path with flags 0010.
        cyc(8'h09, 16'h0, 4'b0010, 1'b0);
        cyc(8'h0A, 16'h0, 4'b0010, 1'b0);
        cyc(8'h0B, 16'h0, 4'b0010, 1'b0);
        chk("add_status_pre", status_reg, 4'b0000);
        cyc(8'h00, 16'h0, 4'b0010, 1'b0);
        chk("add_status", status_reg, 4'b0010);
        chk("add_retired", retired, 16'h0002);

        // Stall three cycles in push state 0x15; mem_we fires only once stall drops.
        cyc(8'h15, 16'h0, 4'h0, 1'b0);
        repeat (3) cyc(8'h00, 16'h5555, 4'b1111, 1'b1);
        chk("stall_state", state, 8'h15);
        chk("stall_status", status_reg, 4'b0010);
        chk("stall_retired", retired, 16'h0002);
        cyc(8'h00, 16'h5555, 4'b1111, 1'b0);
        chk("stall_after_retired", retired, 16'h0003);

        // Undefined state: no strobes, exit counts as a completion.
        cyc(8'h7F, 16'h0, 4'h0, 1'b0);
        cyc(8'h00, 16'h0, 4'hF, 1'b0);
        chk("undef_retired", retired, 16'h0004);
        chk("undef_status", status_reg, 4'b0010);

        // Walk the remaining decoded and some undefined codes with random flags and stalls.
        foreach (sweep[i]) begin
            cyc(sweep[i], 16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
        end
        cyc(8'h00, 16'h0, 4'h0, 1'b0);

        // Reset mid-add: load nonzero status first, then abort in 0x0A.
        cyc(8'h0B, 16'h0, 4'b1000, 1'b0);
        cyc(8'h09, 16'h0, 4'b1000, 1'b0);
        cyc(8'h0A, 16'h0, 4'b1000, 1'b0);
        chk("midadd_state_pre", state, 8'h0A);
        chk("midadd_status_pre", status_reg, 4'b1000);
        next_state = 8'h0B;
        alu_flags  = 4'b1001;
        stall      = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midadd_state", state, 8'h00);
        chk("midadd_status", status_reg, 4'h0);
        chk("midadd_strobes", {ir_load, pc_inc, pc_load, rf_we, mem_we, flags_we, instr_done}, 7'b0);
        chk("midadd_alu", alu_op, 3'b000);
        @(posedge clk);
        #1;
        chk("midadd_state_hold", state, 8'h00);
        chk("midadd_status_hold", status_reg, 4'h0);
        chk("midadd_rf_we", rf_we, 1'b0);
        chk("midadd_retired", retired, 16'h0);
        reset = 1'b0;
        model_reset();

        // Counter wrap on the 8-bit instance; 16-bit instance keeps counting.
        for (int i = 0; i < 257; i++) begin
            cyc(8'h01, 16'h0, 4'h0, 1'b0);
            cyc(8'h00, 16'h0, 4'h0, 1'b0);
            if (i == 254) chk("wrap_pre", retired_b, 8'hFF);
            if (i == 255) begin
                chk("wrap_zero", retired_b, 8'h00);
                chk("wide_256", retired, 16'h0100);
            end
        end
        chk("wrap_one", retired_b, 8'h01);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
